// File: rtl/bananachine_pkg.sv
// Shared types and encodings for the Bananachine 16-bit core control path:
// state enum, op/ext op constants and PC/writeback source selects.
package bananachine_pkg;

    typedef enum logic [3:0] {
        RESET_S = 4'd0,
        FETCH   = 4'd1,
        DECODE  = 4'd2,
        EXEC_R  = 4'd3,
        EXEC_I  = 4'd4,
        MEM_RD  = 4'd5,
        MEM_WB  = 4'd6,
        MEM_WR  = 4'd7,
        BRANCH  = 4'd8,
        JUMP    = 4'd9
    } state_t;

    localparam logic [3:0] OP_RTYPE   = 4'b0000;
    localparam logic [3:0] OP_SPECIAL = 4'b0100;
    localparam logic [3:0] OP_BCOND   = 4'b1100;

    localparam logic [3:0] EXT_LOAD  = 4'b0000;
    localparam logic [3:0] EXT_STOR  = 4'b0100;
    localparam logic [3:0] EXT_JAL   = 4'b1000;
    localparam logic [3:0] EXT_JCOND = 4'b1100;

    localparam logic [1:0] PC_SRC_INC    = 2'b00;
    localparam logic [1:0] PC_SRC_BRANCH = 2'b01;
    localparam logic [1:0] PC_SRC_REG    = 2'b10;

    localparam logic [1:0] WB_SRC_ALU = 2'b00;
    localparam logic [1:0] WB_SRC_MEM = 2'b01;
    localparam logic [1:0] WB_SRC_PC  = 2'b10;

endpackage

// File: rtl/control_decode.sv
// Combinational next-state selection for the DECODE state, from the latched
// op code and extended op code.
module control_decode
    import bananachine_pkg::*;
#(
    parameter int OP_CODE_BITS     = 4,
    parameter int EXT_OP_CODE_BITS = 4
) (
    input  logic [OP_CODE_BITS-1:0]     op_code,
    input  logic [EXT_OP_CODE_BITS-1:0] ext_op_code,
    output state_t                      next_state,
    output logic                        illegal
);

    always_comb begin
        next_state = EXEC_I;
        illegal    = 1'b0;
        case (op_code)
            OP_RTYPE: next_state = EXEC_R;
            OP_BCOND: next_state = BRANCH;
            OP_SPECIAL: begin
                case (ext_op_code)
                    EXT_LOAD:            next_state = MEM_RD;
                    EXT_STOR:            next_state = MEM_WR;
                    EXT_JAL, EXT_JCOND:  next_state = JUMP;
                    default: begin
                        // Undefined special-class encoding: drop it and refetch.
                        next_state = FETCH;
                        illegal    = 1'b1;
                    end
                endcase
            end
            default: next_state = EXEC_I;
        endcase
    end

endmodule

// File: rtl/control_fsm.sv
// Multicycle control FSM for the Bananachine core: fetch, decode, execute,
// memory and writeback sequencing with a memory-ready handshake.
module control_fsm
    import bananachine_pkg::*;
#(
    parameter int WIDTH            = 16,
    parameter int OP_CODE_BITS     = 4,
    parameter int EXT_OP_CODE_BITS = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [OP_CODE_BITS-1:0]     op_code,
    input  logic [EXT_OP_CODE_BITS-1:0] ext_op_code,
    input  logic                        mem_ready,
    input  logic                        cond_true,
    output logic                        instruction_en,
    output logic                        pc_en,
    output logic [1:0]                  pc_src,
    output logic                        addr_src,
    output logic                        mem_read,
    output logic                        mem_write,
    output logic                        alu_src_b,
    output logic                        reg_write,
    output logic [1:0]                  wb_src,
    output logic                        flags_en,
    output logic                        illegal,
    output logic [3:0]                  state
);

    if (WIDTH < OP_CODE_BITS) begin : g_bad_width
        $error("control_fsm: WIDTH must be at least OP_CODE_BITS");
    end

    state_t state_q;
    state_t dec_next;
    logic   dec_illegal;

    control_decode #(
        .OP_CODE_BITS    (OP_CODE_BITS),
        .EXT_OP_CODE_BITS(EXT_OP_CODE_BITS)
    ) u_decode (
        .op_code    (op_code),
        .ext_op_code(ext_op_code),
        .next_state (dec_next),
        .illegal    (dec_illegal)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= RESET_S;
        end else begin
            case (state_q)
                RESET_S: state_q <= FETCH;
                FETCH:   if (mem_ready) state_q <= DECODE;
                DECODE:  state_q <= dec_next;
                MEM_RD:  if (mem_ready) state_q <= MEM_WB;
                MEM_WR:  if (mem_ready) state_q <= FETCH;
                default: state_q <= FETCH;
            endcase
        end
    end

    assign state = state_q;

    // Outputs are decoded from the state so an async reset zeroes them at once.
    always_comb begin
        instruction_en = 1'b0;
        pc_en          = 1'b0;
        pc_src         = PC_SRC_INC;
        addr_src       = 1'b0;
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        alu_src_b      = 1'b0;
        reg_write      = 1'b0;
        wb_src         = WB_SRC_ALU;
        flags_en       = 1'b0;
        illegal        = 1'b0;
        case (state_q)
            FETCH: begin
                mem_read       = 1'b1;
                instruction_en = mem_ready;
                pc_en          = mem_ready;
            end
            DECODE: illegal = dec_illegal;
            EXEC_R: begin
                reg_write = 1'b1;
                flags_en  = 1'b1;
            end
            EXEC_I: begin
                reg_write = 1'b1;
                flags_en  = 1'b1;
                alu_src_b = 1'b1;
            end
            MEM_RD: begin
                mem_read = 1'b1;
                addr_src = 1'b1;
            end
            MEM_WB: begin
                reg_write = 1'b1;
                wb_src    = WB_SRC_MEM;
            end
            MEM_WR: begin
                mem_write = 1'b1;
                addr_src  = 1'b1;
            end
            BRANCH: begin
                pc_en  = cond_true;
                pc_src = PC_SRC_BRANCH;
            end
            JUMP: begin
                pc_src = PC_SRC_REG;
                if (ext_op_code == EXT_JAL) begin
                    pc_en     = 1'b1;
                    reg_write = 1'b1;
                    wb_src    = WB_SRC_PC;
                end else begin
                    pc_en = cond_true;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_fsm.sv
// Bench for control_fsm: per-cycle trace model built from instruction classes,
// directed vector table, reset corner sequences and randomized instructions.
module tb_control_fsm;
    import bananachine_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] op_code = 4'd0;
    logic [3:0] ext_op_code = 4'd0;
    logic       mem_ready = 1'b0;
    logic       cond_true = 1'b0;
    logic       instruction_en, pc_en, addr_src, mem_read, mem_write;
    logic       alu_src_b, reg_write, flags_en, illegal;
    logic [1:0] pc_src, wb_src;
    logic [3:0] state;

    control_fsm dut (
        .clk(clk), .reset(reset), .op_code(op_code), .ext_op_code(ext_op_code),
        .mem_ready(mem_ready), .cond_true(cond_true),
        .instruction_en(instruction_en), .pc_en(pc_en), .pc_src(pc_src),
        .addr_src(addr_src), .mem_read(mem_read), .mem_write(mem_write),
        .alu_src_b(alu_src_b), .reg_write(reg_write), .wb_src(wb_src),
        .flags_en(flags_en), .illegal(illegal), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] st;
        logic       ie, pe;
        logic [1:0] ps;
        logic       as, mr, mw, ab, rw;
        logic [1:0] wb;
        logic       fe, ill;
    } outs_t;

    typedef struct {
        logic  rdy;
        outs_t exp;
    } cyc_t;

    typedef struct {
        logic [3:0] op;
        logic [3:0] ext;
        logic       cond;
        int         fw;
        int         mw;
        int         exp_len;
    } vec_t;

    typedef enum int {K_R, K_I, K_LD, K_ST, K_JAL, K_JC, K_BR, K_ILL} kind_t;

    int   n_cmp = 0;
    int   n_fail = 0;
    cyc_t q[$];

    function automatic outs_t blank(state_t s);
        outs_t o = '0;
        o.st = s;
        return o;
    endfunction

    function automatic outs_t sample();
        outs_t o;
        o.st = state;        o.ie = instruction_en; o.pe = pc_en;
        o.ps = pc_src;       o.as = addr_src;       o.mr = mem_read;
        o.mw = mem_write;    o.ab = alu_src_b;      o.rw = reg_write;
        o.wb = wb_src;       o.fe = flags_en;       o.ill = illegal;
        return o;
    endfunction

    function automatic kind_t classify(logic [3:0] op, logic [3:0] ext);
        if (op == 4'b0000) return K_R;
        if (op == 4'b1100) return K_BR;
        if (op != 4'b0100) return K_I;
        case (ext)
            4'b0000: return K_LD;
            4'b0100: return K_ST;
            4'b1000: return K_JAL;
            4'b1100: return K_JC;
            default: return K_ILL;
        endcase
    endfunction

    task automatic check(string name, outs_t a, outs_t e);
        n_cmp++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, a, e, $time);
        end
    endtask

    task automatic push(logic rdy, outs_t e);
        cyc_t c;
        c.rdy = rdy;
        c.exp = e;
        q.push_back(c);
    endtask

    // Expected cycle-by-cycle trace of one instruction.
    task automatic build(logic [3:0] op, logic [3:0] ext, logic cond, int fw, int mw);
        outs_t e;
        kind_t k = classify(op, ext);
        q.delete();
        e = blank(FETCH); e.mr = 1'b1;
        for (int i = 0; i < fw; i++) push(1'b0, e);
        e.ie = 1'b1; e.pe = 1'b1;
        push(1'b1, e);
        e = blank(DECODE); e.ill = (k == K_ILL);
        push(1'($urandom), e);
        case (k)
            K_R:  begin e = blank(EXEC_R); e.rw = 1; e.fe = 1; push(1'($urandom), e); end
            K_I:  begin e = blank(EXEC_I); e.rw = 1; e.fe = 1; e.ab = 1; push(1'($urandom), e); end
            K_LD: begin
                e = blank(MEM_RD); e.mr = 1; e.as = 1;
                for (int i = 0; i < mw; i++) push(1'b0, e);
                push(1'b1, e);
                e = blank(MEM_WB); e.rw = 1; e.wb = 2'b01;
                push(1'($urandom), e);
            end
            K_ST: begin
                e = blank(MEM_WR); e.mw = 1; e.as = 1;
                for (int i = 0; i < mw; i++) push(1'b0, e);
                push(1'b1, e);
            end
            K_BR:  begin e = blank(BRANCH); e.pe = cond; e.ps = 2'b01; push(1'($urandom), e); end
            K_JAL: begin
                e = blank(JUMP); e.rw = 1; e.wb = 2'b10; e.pe = 1; e.ps = 2'b10;
                push(1'($urandom), e);
            end
            K_JC:  begin e = blank(JUMP); e.pe = cond; e.ps = 2'b10; push(1'($urandom), e); end
            default: ;
        endcase
    endtask

    task automatic run_instr(string name, logic [3:0] op, logic [3:0] ext, logic cond,
                             int fw, int mw, output int len);
        outs_t a;
        bit    left = 0;
        bit    done = 0;
        build(op, ext, cond, fw, mw);
        len = 0;
        foreach (q[i]) begin
            @(negedge clk);
            if (i == 0) begin
                op_code = op; ext_op_code = ext; cond_true = cond;
            end
            mem_ready = q[i].rdy;
            #1;
            a = sample();
            check(name, a, q[i].exp);
            if (!done) begin
                if (a.st != 4'(FETCH)) left = 1;
                else if (left) done = 1;
                if (!done) len++;
            end
        end
    endtask

    vec_t tbl[12];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        outs_t e;
        int    len;
        tbl = '{
            '{4'h0, 4'h0, 1'b0, 0, 0, 3},   // R-type
            '{4'h3, 4'h0, 1'b0, 1, 0, 4},   // I-type, one fetch wait
            '{4'h4, 4'h0, 1'b0, 0, 2, 6},   // load, two memory waits
            '{4'h4, 4'h4, 1'b0, 0, 0, 3},   // store
            '{4'h4, 4'h4, 1'b1, 0, 1, 4},   // store, one wait
            '{4'hC, 4'h0, 1'b1, 0, 0, 3},   // branch taken
            '{4'hC, 4'h0, 1'b0, 0, 0, 3},   // branch not taken
            '{4'h4, 4'h8, 1'b0, 0, 0, 3},   // JAL
            '{4'h4, 4'hC, 1'b1, 0, 0, 3},   // Jcond taken
            '{4'h4, 4'hC, 1'b0, 0, 0, 3},   // Jcond not taken
            '{4'h4, 4'h2, 1'b0, 0, 0, 2},   // illegal special
            '{4'hF, 4'h7, 1'b1, 0, 0, 3}    // other op as I-type
        };

        // Held in reset: everything low regardless of inputs.
        @(negedge clk); mem_ready = 1'b1; cond_true = 1'b1; #1;
        check("reset_hold", sample(), blank(RESET_S));
        @(negedge clk); reset = 1'b1; #1;
        check("reset_release", sample(), blank(RESET_S));

        foreach (tbl[i]) begin
            run_instr($sformatf("vec%0d", i), tbl[i].op, tbl[i].ext, tbl[i].cond,
                      tbl[i].fw, tbl[i].mw, len);
            n_cmp++;
            if (len != tbl[i].exp_len) begin
                n_fail++;
                $display("FAIL vec%0d_len: got %0d cycles expected %0d", i, len, tbl[i].exp_len);
            end
        end

        // Reset asserted in the middle of a stalled store.
        @(negedge clk); op_code = 4'h4; ext_op_code = 4'h4; mem_ready = 1'b1; #1;
        e = blank(FETCH); e.mr = 1; e.ie = 1; e.pe = 1;
        check("rst_st_fetch", sample(), e);
        @(negedge clk); #1;
        check("rst_st_decode", sample(), blank(DECODE));
        @(negedge clk); mem_ready = 1'b0; #1;
        e = blank(MEM_WR); e.mw = 1; e.as = 1;
        check("rst_st_memwr", sample(), e);
        #2 reset = 1'b0; #1;
        check("rst_async_drop", sample(), blank(RESET_S));
        @(negedge clk); #1;
        check("rst_still_low", sample(), blank(RESET_S));
        reset = 1'b1; #1;
        check("rst_released", sample(), blank(RESET_S));
        @(negedge clk); mem_ready = 1'b0; #1;
        e = blank(FETCH); e.mr = 1;
        check("rst_refetch", sample(), e);

        // Randomized instruction stream.
        for (int n = 0; n < 60; n++) begin
            logic [3:0] op, ext;
            op = 4'($urandom_range(0, 15));
            if (n % 3 == 0) op = 4'h4;
            if ($urandom_range(0, 3) == 0) ext = 4'($urandom_range(0, 15));
            else ext = 4'($urandom_range(0, 3)) << 2;
            run_instr($sformatf("rand%0d", n), op, ext, 1'($urandom),
                      $urandom_range(0, 2), $urandom_range(0, 2), len);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/control_fsm.md
# control_fsm

Multicycle control state machine for the Bananachine 16-bit core. Sequences each instruction through fetch, decode, execute, memory and writeback. Drives the instruction-register load enable, PC update, register-file write, ALU operand select and memory strobes. Decodes the latched 4-bit op code and 4-bit extended op code; it waits on a memory-ready handshake for every fetch, load and store.

## Interface
- `WIDTH`, 16, datapath width; documentation only, no port depends on it.
- `OP_CODE_BITS`, 4, width of `op_code`.
- `EXT_OP_CODE_BITS`, 4, width of `ext_op_code`.

Ports:
- `clk`  in  1  rising-edge clock; single clock domain.
- `reset`  in  1  asynchronous, active-low reset.
- `op_code`  in  OP_CODE_BITS  latched op code from the instruction register.
- `ext_op_code`  in  EXT_OP_CODE_BITS  latched extended op code.
- `mem_ready`  in  1  memory completes the current read/write this cycle.
- `cond_true`  in  1  branch/jump condition met (from the flag unit).
- `instruction_en`  out  1  load the instruction register.
- `pc_en`  out  1  write the PC.
- `pc_src`  out  2  PC source: 00 = PC+1, 01 = branch target, 10 = register B.
- `addr_src`  out  1  memory address: 0 = PC, 1 = register B.
- `mem_read`  out  1  memory read strobe.
- `mem_write`  out  1  memory write strobe.
- `alu_src_b`  out  1  ALU operand B: 0 = register B, 1 = immediate.
- `reg_write`  out  1  write register A.
- `wb_src`  out  2  writeback source: 00 = ALU, 01 = memory data, 10 = PC.
- `flags_en`  out  1  update the PSR flags.
- `illegal`  out  1  one-cycle pulse on an undefined encoding.
- `state`  out  4  current state encoding, for debug.

## Operation
- States: `RESET_S`, `FETCH`, `DECODE`, `EXEC_R`, `EXEC_I`, `MEM_RD`, `MEM_WB`, `MEM_WR`, `BRANCH`, `JUMP`.
- `RESET_S` (entered while `reset` = 0): all outputs 0. Exits to `FETCH` on the first clock after release.
- `FETCH`:
  - `mem_read`=1, `addr_src`=0.
  - On `mem_ready`, assert `instruction_en`=1 and `pc_en`=1 (`pc_src`=00) in that same cycle, then go to `DECODE`.
  - Otherwise hold in `FETCH`, with `instruction_en`=0 and `pc_en`=0.
- `DECODE`: no outputs asserted. The next state is chosen from `op_code`/`ext_op_code`:
  - `0000` → `EXEC_R`.
  - `0100` with ext `0000` → `MEM_RD`; ext `0100` → `MEM_WR`; ext `1000` or `1100` → `JUMP`.
  - `0100` with any other ext → pulse `illegal`, go to `FETCH`.
  - `1100` → `BRANCH`.
  - Any other op → `EXEC_I`.
- `EXEC_R`: `reg_write`=1, `wb_src`=00, `alu_src_b`=0, `flags_en`=1 → `FETCH`.
- `EXEC_I`: same as `EXEC_R` but `alu_src_b`=1 → `FETCH`.
- `MEM_RD`: `mem_read`=1, `addr_src`=1. Hold until `mem_ready`, then go to `MEM_WB`.
- `MEM_WB`: `reg_write`=1, `wb_src`=01 → `FETCH`.
- `MEM_WR`: `mem_write`=1, `addr_src`=1. Hold until `mem_ready`, then go to `FETCH`.
- `BRANCH`: `pc_en`=`cond_true`, `pc_src`=01 → `FETCH`.
- `JUMP`:
  - JAL (ext `1000`): `reg_write`=1, `wb_src`=10, `pc_en`=1, `pc_src`=10.
  - Jcond (ext `1100`): `pc_en`=`cond_true`, `pc_src`=10, no register write.
  - Both → `FETCH`.
- Output rules:
  - Outputs are combinational from the registered state plus `mem_ready`/`cond_true`.
  - Any output not listed for a state is 0.
  - `mem_read` and `mem_write` are never both 1.

## Timing
- Latency with zero-wait memory:
  - R/I-type, branch, jump: 3 cycles each.
  - Load: 4 cycles.
  - Store: 3 cycles.
- Each cycle with `mem_ready`=0 in `FETCH`, `MEM_RD` or `MEM_WR` adds one cycle. Strobes stay constant while waiting.
- `instruction_en` is a single-cycle pulse per instruction. `op_code` is stable from `DECODE` onward.
- `reset` asserted mid-instruction:
  - State → `RESET_S` immediately (asynchronously), and all outputs drop to 0 in the same cycle.
  - Any in-flight memory access is abandoned.
- `illegal` is high for exactly the one `DECODE` cycle; the next cycle is `FETCH`.

## Structure
- `bananachine_pkg` holds:
  - state enum;
  - op code constants: `OP_RTYPE`=0000, `OP_SPECIAL`=0100, `OP_BCOND`=1100;
  - special-class ext constants: `EXT_LOAD`=0000, `EXT_STOR`=0100, `EXT_JAL`=1000, `EXT_JCOND`=1100;
  - `pc_src` and `wb_src` encodings.
- One sub-module, `control_decode`: purely combinational next-state selection from `op_code`/`ext_op_code`, used in `DECODE`.
- The state register and output logic live in `control_fsm`.

## Test plan
- Reset released, `mem_ready`=1, `op_code`=0000 → `FETCH`, `DECODE`, `EXEC_R`. `instruction_en` and `pc_en` are high in cycle 1 only; `reg_write`, `flags_en` high in cycle 3 with `alu_src_b`=0.
- Load (0100/0000) with `mem_ready` low for 2 cycles in `MEM_RD` → `mem_read`=1, `addr_src`=1 held for 3 cycles. Next cycle `reg_write`=1, `wb_src`=01; total 6 cycles.
- `BRANCH` test:
  - Bcond with `cond_true`=1 → `pc_en`=1, `pc_src`=01 in cycle 3.
  - Repeat with `cond_true`=0 → `pc_en`=0; next state `FETCH`.
- JAL (0100/1000) → in `JUMP`: `reg_write`=1, `wb_src`=10, `pc_en`=1, `pc_src`=10.
- `op_code`=0100, ext=0010 → `illegal` pulses one cycle in `DECODE`; no `reg_write`/`mem_*`; returns to `FETCH`.
- `reset` driven low mid-`MEM_WR` with `mem_write`=1 → `mem_write` drops immediately; `state`=`RESET_S`. After release: `FETCH` with `mem_read`=1.
